cordic_rr_sequencer: RTL and testbench

- Multi-cycle controller that shares one iterative CORDIC rotation engine between two angle requesters.
- Round-robin arbitration selects a requester. The block then drives the combinational angle-reduction stage, rebuilds the in-quadrant angle, and runs ITER shift-add micro-rotations.
- A quadrant fold-back produces signed cos/sin, returned through a valid/ready output tagged with the requester id.
- Sits between the angle sources and the sin/cos consumers.

---
 rtl/cordic_rr_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_cordic_rr_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_sequencer.sv
// Two-requester round-robin front end sharing one iterative CORDIC sin/cos engine.
// Latency ITER+2 cycles accept-to-valid (1 on out-of-range angle); result held until out_ready, no accept until drained.
module cordic_rr_sequencer #(
    parameter int          ITER  = 14,
    parameter logic [15:0] KINIT = 16'h26DD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [17:0] req0_theta,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [17:0] req1_theta,
    output logic        req1_ready,
    output logic [17:0] pre_theta,
    input  logic [12:0] pre_phi,
    input  logic        pre_d0,
    input  logic        pre_d1,
    input  logic        pre_q0,
    input  logic        pre_q1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_id,
    output logic [15:0] out_cos,
    output logic [15:0] out_sin,
    output logic        out_err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, REDUCE, ITERATE, POST, DONE} state_t;

    localparam logic [17:0] THETA_MAX = 18'h1921F;

    state_t             state;
    logic               rr;
    logic               id_q;
    logic [17:0]        theta_q;
    logic [1:0]         quad_q;
    logic [3:0]         iter;
    logic signed [17:0] x, y, z;

    logic               grant0, grant1;
    logic [17:0]        phi_ext;
    logic [17:0]        a_rebuilt;
    logic signed [17:0] x_sh, y_sh, at;
    logic signed [17:0] x_nxt, y_nxt, z_nxt;
    logic signed [17:0] c_raw, s_raw;

    function automatic logic signed [17:0] atan_lut(input logic [3:0] k);
        case (k)
            4'd0:    return 18'sd12868;
            4'd1:    return 18'sd7596;
            4'd2:    return 18'sd4014;
            4'd3:    return 18'sd2037;
            4'd4:    return 18'sd1023;
            4'd5:    return 18'sd512;
            4'd6:    return 18'sd256;
            4'd7:    return 18'sd128;
            4'd8:    return 18'sd64;
            4'd9:    return 18'sd32;
            4'd10:   return 18'sd16;
            4'd11:   return 18'sd8;
            4'd12:   return 18'sd4;
            4'd13:   return 18'sd2;
            default: return 18'sd1;
        endcase
    endfunction

    function automatic logic [15:0] sat_q14(input logic signed [17:0] v);
        if (v > 18'sd16384)
            return 16'h4000;
        else if (v < -18'sd16384)
            return 16'hC000;
        else
            return v[15:0];
    endfunction

    // rr names the requester that wins when both are asking
    assign grant0     = req0_valid & (~req1_valid | ~rr);
    assign grant1     = req1_valid & (~req0_valid | rr);
    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign pre_theta  = theta_q;
    assign busy       = (state != IDLE);

    always_comb begin
        phi_ext = {5'd0, pre_phi};
        case ({pre_d1, pre_d0})
            2'b00:   a_rebuilt = phi_ext;
            2'b01:   a_rebuilt = 18'h3243 - phi_ext;
            2'b10:   a_rebuilt = 18'h3243 + phi_ext;
            default: a_rebuilt = 18'h6487 - phi_ext;
        endcase
    end

    always_comb begin
        x_sh = x >>> iter;
        y_sh = y >>> iter;
        at   = atan_lut(iter);
        if (!z[17]) begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - at;
        end else begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + at;
        end
    end

    always_comb begin
        case (quad_q)
            2'd0:    begin c_raw = x;  s_raw = y;  end
            2'd1:    begin c_raw = -y; s_raw = x;  end
            2'd2:    begin c_raw = -x; s_raw = -y; end
            default: begin c_raw = y;  s_raw = -x; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= 1'b0;
            id_q      <= 1'b0;
            theta_q   <= '0;
            quad_q    <= '0;
            iter      <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            out_cos   <= '0;
            out_sin   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        theta_q <= grant0 ? req0_theta : req1_theta;
                        id_q    <= grant1;
                        rr      <= grant0;
                        state   <= REDUCE;
                    end
                end
                REDUCE: begin
                    quad_q <= {pre_q1, pre_q0};
                    x      <= $signed({2'b00, KINIT});
                    y      <= '0;
                    z      <= $signed(a_rebuilt);
                    iter   <= '0;
                    if (theta_q > THETA_MAX) begin
                        out_err   <= 1'b1;
                        out_cos   <= '0;
                        out_sin   <= '0;
                        out_id    <= id_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= ITERATE;
                    end
                end
                ITERATE: begin
                    x    <= x_nxt;
                    y    <= y_nxt;
                    z    <= z_nxt;
                    iter <= iter + 4'd1;
                    if (iter == 4'(ITER - 1))
                        state <= POST;
                end
                POST: begin
                    out_cos   <= sat_q14(c_raw);
                    out_sin   <= sat_q14(s_raw);
                    out_id    <= id_q;
                    out_err   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rr_sequencer.sv
// Scoreboard bench for cordic_rr_sequencer with a behavioural angle-reduction stage.
module tb_cordic_rr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [17:0] req0_theta, req1_theta;
    logic        req0_ready, req1_ready;
    logic [17:0] pre_theta;
    logic [12:0] pre_phi;
    logic        pre_d0, pre_d1, pre_q0, pre_q1;
    logic        out_valid, out_ready, out_id, out_err, busy;
    logic [15:0] out_cos, out_sin;

    typedef struct {
        bit id;
        bit err;
        int c;
        int s;
        int tol;
    } exp_t;

    exp_t sb[$];
    int   arb_ids[$];
    bit   arb_rec = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_viol  = 0;

    always #5 clk = ~clk;

    cordic_rr_sequencer #(.ITER(14), .KINIT(16'h26DD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_theta(req0_theta), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_theta(req1_theta), .req1_ready(req1_ready),
        .pre_theta(pre_theta), .pre_phi(pre_phi),
        .pre_d0(pre_d0), .pre_d1(pre_d1), .pre_q0(pre_q0), .pre_q1(pre_q1),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_cos(out_cos), .out_sin(out_sin), .out_err(out_err), .busy(busy)
    );

    // Quadrant of pi/2 = 25735 LSB, then residual split into four sub-ranges whose phi fits 13 bits
    function automatic logic [16:0] reduce_model(input logic [17:0] th);
        int t, q, r, d, phi;
        logic [31:0] qv, dv, pv;
        t = int'(th);
        q = t / 25735;
        r = t - q * 25735;
        if (q > 3) begin
            q = 0;
            r = t - 4 * 25735;
        end
        if (r < 8192)       begin d = 0; phi = r;         end
        else if (r < 12867) begin d = 1; phi = 12867 - r; end
        else if (r < 21059) begin d = 2; phi = r - 12867; end
        else                begin d = 3; phi = 25735 - r; end
        qv = q;
        dv = d;
        pv = phi;
        return {qv[1:0], dv[1:0], pv[12:0]};
    endfunction

    always_comb begin
        {pre_q1, pre_q0, pre_d1, pre_d0, pre_phi} = reduce_model(pre_theta);
    end

    // Hand-computed cos/sin * 16384; tolerance absorbs CORDIC residual angle and shift truncation
    function automatic exp_t expect_of(input bit id, input logic [17:0] th);
        exp_t e;
        e.id = id; e.err = 1'b0; e.tol = 8;
        case (th)
            18'h00000: begin e.c = 16384;  e.s = 0;      end
            18'h06487: begin e.c = 0;      e.s = 16384;  end
            18'h0C90F: begin e.c = -16384; e.s = 0;      end
            18'h03243: begin e.c = 11585;  e.s = 11585;  end
            18'h15F90: begin e.c = 11532;  e.s = -11639; end
            18'h12D97: begin e.c = 0;      e.s = -16384; end
            18'h1921F: begin e.c = 16384;  e.s = 0;      end
            18'h10000: begin e.c = -10709; e.s = -12399; end
            default: begin
                e.c = 0; e.s = 0; e.tol = 0;
                e.err = (th > 18'h1921F);
                if (!e.err) e.c = 99999;
            end
        endcase
        return e;
    endfunction

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit near(input int a, input int b, input int tol);
        return (a - b <= tol) && (b - a <= tol);
    endfunction

    // Accept logger: handshakes seen here complete on the following rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                sb.push_back(expect_of(1'b0, req0_theta));
                if (arb_rec) arb_ids.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(expect_of(1'b1, req1_theta));
                if (arb_rec) arb_ids.push_back(1);
            end
            if ((req0_ready && req1_ready) || (busy && (req0_ready || req1_ready)))
                n_viol++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   c, s;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1'b0, 1, 0);
            end else begin
                e = sb.pop_front();
                c = int'($signed(out_cos));
                s = int'($signed(out_sin));
                check("out_id",  out_id == e.id,  int'(out_id),  int'(e.id));
                check("out_err", out_err == e.err, int'(out_err), int'(e.err));
                check("out_cos", near(c, e.c, e.tol), c, e.c);
                check("out_sin", near(s, e.s, e.tol), s, e.s);
            end
        end
    end

    task automatic issue(input bit id, input logic [17:0] th);
        bit got = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_theta = th; end
        else    begin req0_valid = 1'b1; req0_theta = th; end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 1'b0, 0, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic measure_lat(input int exp_lat);
        int n = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        check("latency", out_valid && (n == exp_lat), n, exp_lat);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !busy && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 1'b0, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [17:0] vec_theta [8];
    bit          vec_id    [8];
    int          vec_lat   [8];

    initial begin
        logic [15:0] hc, hs;
        logic        hid, herr;
        bit          stable, bad_acc;
        int          nv;

        vec_theta = '{18'h00000, 18'h06487, 18'h0C90F, 18'h03243,
                      18'h15F90, 18'h12D97, 18'h1921F, 18'h10000};
        vec_id    = '{0, 1, 1, 0, 0, 1, 0, 1};
        vec_lat   = '{16, 16, 16, 16, 16, 16, 16, 16};

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_theta = '0;   req1_theta = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check("rst_busy",      busy == 1'b0,      int'(busy),      0);
        check("rst_cos_sin",   {out_cos, out_sin} == 32'd0, int'({out_cos, out_sin}), 0);
        check("rst_id_err",    {out_id, out_err} == 2'd0,   int'({out_id, out_err}),   0);
        check("rst_pre_theta", pre_theta == 18'd0, int'(pre_theta), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both requesters held valid: rr starts at 0 after reset
        arb_rec = 1'b1;
        req0_theta = 18'h00000;
        req1_theta = 18'h06487;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (arb_ids.size() >= 4) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        arb_rec = 1'b0;
        drain();
        check("arb_count", arb_ids.size() == 4, arb_ids.size(), 4);
        for (int k = 0; k < arb_ids.size(); k++)
            check("arb_order", arb_ids[k] == (k % 2), arb_ids[k], k % 2);

        for (int v = 0; v < 8; v++) begin
            issue(vec_id[v], vec_theta[v]);
            measure_lat(vec_lat[v]);
            drain();
        end

        // Consumer stalls: result must hold and no other request may slip in
        out_ready = 1'b0;
        issue(1'b0, 18'h03243);
        measure_lat(16);
        hc = out_cos; hs = out_sin; hid = out_id; herr = out_err;
        req1_theta = 18'h0C90F;
        req1_valid = 1'b1;
        stable = 1'b1;
        bad_acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_cos != hc || out_sin != hs || out_id != hid || out_err != herr)
                stable = 1'b0;
            if (req1_ready || req0_ready) bad_acc = 1'b1;
        end
        check("hold_stable",    stable,   int'(stable),  1);
        check("hold_no_accept", !bad_acc, int'(bad_acc), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid_drop", out_valid == 1'b0, int'(out_valid), 0);
        check("release_idle",       busy == 1'b0,      int'(busy),      0);
        for (int k = 0; k < 20; k++) begin
            if (req1_ready) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        drain();

        issue(1'b0, 18'h1FFFF);
        measure_lat(1);
        drain();
        issue(1'b1, 18'h19220);
        measure_lat(1);
        drain();

        // Reset in the middle of ITERATE discards the job
        issue(1'b1, 18'h10000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",      busy == 1'b0,      int'(busy),      0);
        check("midrst_valid",     out_valid == 1'b0, int'(out_valid), 0);
        check("midrst_pre_theta", pre_theta == 18'd0, int'(pre_theta), 0);
        check("midrst_cos",       out_cos == 16'd0,  int'(out_cos),   0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nv = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) nv++;
        end
        check("midrst_no_output", nv == 0, nv, 0);
        issue(1'b1, 18'h10000);
        measure_lat(16);
        drain();

        check("ready_exclusive", n_viol == 0, n_viol, 0);
        check("sb_empty", sb.size() == 0, sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
